pc_fetch_unit: RTL and testbench

Program-counter and fetch-to-decode register block for the five-stage MIPS pipeline. It holds the F-stage PC that drives the instruction-memory fetch path and captures the fetched word into the F/D pipeline register. It also resolves branches and jumps in D, with one architectural delay slot, and selects the next PC. It sits directly upstream of the IFU (drives its PC input) and consumes the IFU's instruction output.

---
 rtl/pc_fetch_unit.sv | 114 +++++++++++
 tb/tb_pc_fetch_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Fetch PC and F/D register for the five-stage MIPS pipeline.
// Branches and jumps resolve in D and have one delay slot.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        PCU_clk_i,
  input  logic        PCU_rstn_i,
  input  logic        PCU_stall_i,
  input  logic [31:0] PCU_instr_F_i,
  input  logic [31:0] PCU_rs_data_D_i,
  input  logic [31:0] PCU_rt_data_D_i,
  output logic [31:0] PCU_pc_F_o,
  output logic [31:0] PCU_instr_D_o,
  output logic [31:0] PCU_pc_D_o,
  output logic        PCU_redirect_D_o
);

  localparam logic [5:0] OP_SPEC  = 6'b000000;
  localparam logic [5:0] OP_REGIM = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;

  logic [31:0] pc_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] next_pc;

  logic [5:0]  op;
  logic [4:0]  rt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [25:0] index;

  assign op    = instr_d[31:26];
  assign rt    = instr_d[20:16];
  assign funct = instr_d[5:0];
  assign imm   = instr_d[15:0];
  assign index = instr_d[25:0];

  logic is_beq, is_bne, is_blez, is_bgtz;
  logic is_bltz, is_bgez, is_jump, is_jreg;

  assign is_beq  = (op == OP_BEQ);
  assign is_bne  = (op == OP_BNE);
  assign is_blez = (op == OP_BLEZ);
  assign is_bgtz = (op == OP_BGTZ);
  assign is_bltz = (op == OP_REGIM) && (rt == 5'b00000);
  assign is_bgez = (op == OP_REGIM) && (rt == 5'b00001);
  assign is_jump = (op == OP_J) || (op == OP_JAL);
  assign is_jreg = (op == OP_SPEC) &&
                   ((funct == FN_JR) || (funct == FN_JALR));

  logic signed [31:0] rs_s;
  logic [31:0]        pc_d4;
  logic [31:0]        br_tgt;
  logic [31:0]        j_tgt;

  assign rs_s   = $signed(PCU_rs_data_D_i);
  assign pc_d4  = pc_d + 32'd4;
  assign br_tgt = pc_d4 + {{14{imm[15]}}, imm, 2'b00};
  assign j_tgt  = {pc_d4[31:28], index, 2'b00};

  logic        taken;
  logic [31:0] target;

  always_comb begin
    taken  = 1'b0;
    target = br_tgt;
    unique case (1'b1)
      is_beq:  taken = (PCU_rs_data_D_i == PCU_rt_data_D_i);
      is_bne:  taken = (PCU_rs_data_D_i != PCU_rt_data_D_i);
      is_blez: taken = (rs_s <= 32'sd0);
      is_bgtz: taken = (rs_s > 32'sd0);
      is_bltz: taken = (rs_s < 32'sd0);
      is_bgez: taken = (rs_s >= 32'sd0);
      is_jump: begin
        taken  = 1'b1;
        target = j_tgt;
      end
      is_jreg: begin
        taken  = 1'b1;
        target = PCU_rs_data_D_i;
      end
      default: taken = 1'b0;
    endcase
  end

  assign next_pc = taken ? target : (pc_f + 32'd4);

  // The delay-slot word is always captured; a stall only freezes.
  always_ff @(posedge PCU_clk_i or negedge PCU_rstn_i) begin
    if (!PCU_rstn_i) begin
      pc_f    <= RESET_PC;
      instr_d <= 32'h0;
      pc_d    <= RESET_PC;
    end else if (!PCU_stall_i) begin
      pc_f    <= next_pc;
      instr_d <= PCU_instr_F_i;
      pc_d    <= pc_f;
    end
  end

  assign PCU_pc_F_o       = pc_f;
  assign PCU_instr_D_o    = instr_d;
  assign PCU_pc_D_o       = pc_d;
  assign PCU_redirect_D_o = taken;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit.
// Expected values are hand-computed per vector.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rstn;
  logic        stall;
  logic [31:0] instr_f;
  logic [31:0] rs_d;
  logic [31:0] rt_d;
  logic [31:0] pc_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic        redir;

  int total = 0;
  int bad   = 0;

  pc_fetch_unit dut (
    .PCU_clk_i        (clk),
    .PCU_rstn_i       (rstn),
    .PCU_stall_i      (stall),
    .PCU_instr_F_i    (instr_f),
    .PCU_rs_data_D_i  (rs_d),
    .PCU_rt_data_D_i  (rt_d),
    .PCU_pc_F_o       (pc_f),
    .PCU_instr_D_o    (instr_d),
    .PCU_pc_D_o       (pc_d),
    .PCU_redirect_D_o (redir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] NOP = 32'h0000_0000;

  initial begin
    rstn    = 1'b0;
    stall   = 1'b0;
    instr_f = NOP;
    rs_d    = '0;
    rt_d    = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_pcf", pc_f, 32'h3000);
    chk("rst_instr", instr_d, 32'h0);
    chk("rst_pcd", pc_d, 32'h3000);
    chk("rst_redir", {31'b0, redir}, 32'h0);

    @(negedge clk);
    rstn = 1'b1;
    tick();
    chk("run_pcf1", pc_f, 32'h3004);
    chk("run_pcd1", pc_d, 32'h3000);
    tick();
    chk("run_pcf2", pc_f, 32'h3008);
    chk("run_pcd2", pc_d, 32'h3004);
    chk("run_redir", {31'b0, redir}, 32'h0);
    tick();
    tick();
    chk("run_pcf4", pc_f, 32'h3010);

    // beq, imm=-2, rs=rt=5
    instr_f = 32'h1000_FFFE;
    tick();
    chk("beq_pcd", pc_d, 32'h3010);
    chk("beq_pcf", pc_f, 32'h3014);
    rs_d = 32'd5;
    rt_d = 32'd5;
    #1;
    chk("beq_redir", {31'b0, redir}, 32'h1);
    instr_f = 32'h2408_0001;
    tick();
    chk("beq_tgt", pc_f, 32'h300C);
    chk("beq_slot", instr_d, 32'h2408_0001);
    chk("beq_slotpc", pc_d, 32'h3014);
    chk("slot_redir", {31'b0, redir}, 32'h0);

    // bne not taken
    instr_f = 32'h1400_0010;
    tick();
    rs_d = 32'd7;
    rt_d = 32'd7;
    #1;
    chk("bne_redir", {31'b0, redir}, 32'h0);
    instr_f = NOP;
    tick();
    chk("bne_seq", pc_f, 32'h3014);
    tick();
    tick();
    tick();
    chk("pre_bltz", pc_f, 32'h3020);

    // bltz taken, imm=4
    instr_f = 32'h0400_0004;
    tick();
    chk("bltz_pcd", pc_d, 32'h3020);
    rs_d = 32'h8000_0000;
    #1;
    chk("bltz_redir", {31'b0, redir}, 32'h1);
    instr_f = NOP;
    tick();
    chk("bltz_tgt", pc_f, 32'h3034);

    // beq stalled while forwarded rt changes
    instr_f = 32'h1000_0002;
    tick();
    chk("sbeq_pcd", pc_d, 32'h3034);
    rs_d = 32'd1;
    rt_d = 32'd2;
    #1;
    chk("sbeq_ne", {31'b0, redir}, 32'h0);
    stall   = 1'b1;
    instr_f = 32'h2409_0002;
    tick();
    chk("stall_pcf", pc_f, 32'h3038);
    chk("stall_ins", instr_d, 32'h1000_0002);
    chk("stall_pcd", pc_d, 32'h3034);
    rt_d = 32'd1;
    #1;
    chk("stall_redir", {31'b0, redir}, 32'h1);
    tick();
    chk("stall2_pcf", pc_f, 32'h3038);
    chk("stall2_ins", instr_d, 32'h1000_0002);
    stall = 1'b0;
    tick();
    chk("unst_tgt", pc_f, 32'h3040);
    chk("unst_slot", instr_d, 32'h2409_0002);
    chk("unst_pcd", pc_d, 32'h3038);

    // jr to 0x3008 to set up jal
    instr_f = 32'h0000_0008;
    tick();
    rs_d = 32'h3008;
    #1;
    chk("jr1_redir", {31'b0, redir}, 32'h1);
    instr_f = NOP;
    tick();
    chk("jr1_tgt", pc_f, 32'h3008);

    instr_f = 32'h0C00_0C40;
    tick();
    chk("jal_pcd", pc_d, 32'h3008);
    chk("jal_redir", {31'b0, redir}, 32'h1);
    instr_f = NOP;
    tick();
    chk("jal_tgt", pc_f, 32'h3100);

    instr_f = 32'h0000_0008;
    tick();
    rs_d = 32'h3ABC;
    instr_f = NOP;
    tick();
    chk("jr_tgt", pc_f, 32'h3ABC);
    chk("jr_pcd", pc_d, 32'h3104);

    // jalr to 0xFFFF_FFFC, then wrap
    instr_f = 32'h0000_0009;
    tick();
    rs_d = 32'hFFFF_FFFC;
    instr_f = NOP;
    tick();
    chk("jalr_tgt", pc_f, 32'hFFFF_FFFC);
    tick();
    chk("wrap", pc_f, 32'h0);

    // bgez, blez, bgtz boundaries at rs around 0
    instr_f = 32'h0401_0003;
    tick();
    rs_d = 32'hFFFF_FFFF;
    #1;
    chk("bgez_neg", {31'b0, redir}, 32'h0);
    rs_d = 32'h0;
    #1;
    chk("bgez_zero", {31'b0, redir}, 32'h1);
    instr_f = 32'h1800_0003;
    tick();
    chk("bgez_tgt", pc_f, 32'h10);
    #1;
    chk("blez_zero", {31'b0, redir}, 32'h1);
    rs_d = 32'd1;
    #1;
    chk("blez_pos", {31'b0, redir}, 32'h0);
    instr_f = 32'h1C00_0003;
    tick();
    chk("blez_seq", pc_f, 32'h14);
    rs_d = 32'h0;
    #1;
    chk("bgtz_zero", {31'b0, redir}, 32'h0);
    rs_d = 32'd5;
    #1;
    chk("bgtz_pos", {31'b0, redir}, 32'h1);

    // async reset between edges
    #1;
    rstn = 1'b0;
    #1;
    chk("arst_pcf", pc_f, 32'h3000);
    chk("arst_ins", instr_d, 32'h0);
    chk("arst_pcd", pc_d, 32'h3000);
    chk("arst_redir", {31'b0, redir}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
